alu_host_master: RTL and testbench

ALU_HOST_MASTER -- requirements
Module: alu_host_master

---
 rtl/alu_host_master_if.sv | 33 +++
 rtl/alu_host_master.sv | 169 ++++++++++++++++
 tb/tb_alu_host_master.sv | 356 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_host_master_if.sv
// alu_host_master_if: command, ALU-slave bus, result and status signals of alu_host_master.
interface alu_host_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_type;
    logic [3:0]  cmd_idx;
    logic [31:0] cmd_data;
    logic        m_sel;
    logic        m_wr;
    logic [15:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_irq;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        busy;
    logic        done;
    logic        ovf_err;
    logic        timeout;

    modport master (
        input  cmd_valid, cmd_type, cmd_idx, cmd_data, m_rdata, m_irq, res_ready,
        output cmd_ready, m_sel, m_wr, m_addr, m_wdata, res_valid, res_data,
               busy, done, ovf_err, timeout
    );

    modport slave (
        output cmd_valid, cmd_type, cmd_idx, cmd_data, m_rdata, m_irq, res_ready,
        input  cmd_ready, m_sel, m_wr, m_addr, m_wdata, res_valid, res_data,
               busy, done, ovf_err, timeout
    );
endinterface

// File: rtl/alu_host_master.sv
// alu_host_master: sequences instruction/operand loads, runs and result pops on a memory-mapped ALU slave.
// Define ALU_HOST_TIMEOUT_EN to add a 4095-cycle watchdog on the interrupt wait.
module alu_host_master (
    input  logic              clk,
    input  logic              reset,
    alu_host_master_if.master bus
);
    typedef enum logic [3:0] {
        IDLE, WR, WR_GAP, START, WAIT_IRQ, RD, RD_CAP, PUSH, CLR, CLR_GAP
    } state_e;

    localparam logic [15:0] A_START = 16'h0000;
    localparam logic [15:0] A_CLR   = 16'h0002;
    localparam logic [15:0] A_INST  = 16'h0003;
    localparam logic [15:0] A_RES   = 16'h0004;
    localparam logic [15:0] A_OPND  = 16'h0010;

    state_e      state_q;
    logic [3:0]  inst_cnt_q;
    logic [4:0]  rd_cnt_q;
    logic        sel_q;
    logic        wr_q;
    logic [15:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] res_data_q;
    logic        res_valid_q;
    logic        done_q;
    logic        ovf_q;
`ifdef ALU_HOST_TIMEOUT_EN
    logic [11:0] tmo_cnt_q;
    logic        tmo_q;
    logic        abort_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            inst_cnt_q  <= '0;
            rd_cnt_q    <= '0;
            sel_q       <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
`ifdef ALU_HOST_TIMEOUT_EN
            tmo_cnt_q   <= '0;
            tmo_q       <= 1'b0;
            abort_q     <= 1'b0;
`endif
        end else begin
            // bus strobes and status pulses last one cycle unless re-armed below
            sel_q   <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef ALU_HOST_TIMEOUT_EN
            tmo_q   <= 1'b0;
`endif
            case (state_q)
                IDLE: if (bus.cmd_valid) begin
                    if (bus.cmd_type == 2'd0 && inst_cnt_q == 4'd8) begin
                        ovf_q <= 1'b1;
                    end else if (bus.cmd_type == 2'd0 || bus.cmd_type == 2'd1) begin
                        sel_q      <= 1'b1;
                        wr_q       <= 1'b1;
                        wdata_q    <= bus.cmd_data;
                        addr_q     <= (bus.cmd_type == 2'd0) ? A_INST : (A_OPND | {12'd0, bus.cmd_idx});
                        inst_cnt_q <= inst_cnt_q + {3'd0, bus.cmd_type == 2'd0};
                        state_q    <= WR;
                    end else if (bus.cmd_type == 2'd2) begin
                        if (inst_cnt_q == 4'd0) begin
                            done_q <= 1'b1;
                        end else begin
                            sel_q    <= 1'b1;
                            wr_q     <= 1'b1;
                            addr_q   <= A_START;
                            wdata_q  <= 32'd1;
                            rd_cnt_q <= {inst_cnt_q, 1'b0};
                            state_q  <= START;
                        end
                    end
                end
                WR:     state_q <= WR_GAP;
                WR_GAP: state_q <= IDLE;
                START: begin
                    state_q <= WAIT_IRQ;
`ifdef ALU_HOST_TIMEOUT_EN
                    tmo_cnt_q <= '0;
`endif
                end
                WAIT_IRQ: begin
                    if (bus.m_irq) begin
                        sel_q   <= 1'b1;
                        addr_q  <= A_RES;
                        state_q <= RD;
                    end
`ifdef ALU_HOST_TIMEOUT_EN
                    else if (tmo_cnt_q == 12'd4094) begin
                        tmo_q      <= 1'b1;
                        abort_q    <= 1'b1;
                        inst_cnt_q <= '0;
                        sel_q      <= 1'b1;
                        wr_q       <= 1'b1;
                        addr_q     <= A_CLR;
                        wdata_q    <= 32'd1;
                        state_q    <= CLR;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 12'd1;
                    end
`endif
                end
                RD: state_q <= RD_CAP;
                RD_CAP: begin
                    res_data_q  <= bus.m_rdata;
                    res_valid_q <= 1'b1;
                    rd_cnt_q    <= rd_cnt_q - 5'd1;
                    state_q     <= PUSH;
                end
                // the next read is only issued once the held result has been taken
                PUSH: if (bus.res_ready) begin
                    res_valid_q <= 1'b0;
                    sel_q       <= 1'b1;
                    if (rd_cnt_q == 5'd0) begin
                        wr_q    <= 1'b1;
                        addr_q  <= A_CLR;
                        wdata_q <= 32'd1;
                        state_q <= CLR;
                    end else begin
                        addr_q  <= A_RES;
                        state_q <= RD;
                    end
                end
                CLR: state_q <= CLR_GAP;
                CLR_GAP: begin
                    state_q    <= IDLE;
                    inst_cnt_q <= '0;
`ifdef ALU_HOST_TIMEOUT_EN
                    done_q     <= ~abort_q;
                    abort_q    <= 1'b0;
`else
                    done_q     <= 1'b1;
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.m_sel     = sel_q;
    assign bus.m_wr      = wr_q;
    assign bus.m_addr    = addr_q;
    assign bus.m_wdata   = wdata_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.done      = done_q;
    assign bus.ovf_err   = ovf_q;
`ifdef ALU_HOST_TIMEOUT_EN
    assign bus.timeout   = tmo_q;
`else
    assign bus.timeout   = 1'b0;
`endif
endmodule

// File: tb/tb_alu_host_master.sv
// tb_alu_host_master: directed tests of alu_host_master against a small ALU slave model.
module tb_alu_host_master;
    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [31:0] data;
    } acc_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    alu_host_master_if bus();

    alu_host_master dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    acc_t        acc_log[$];
    logic [31:0] res_q[$];
    int          done_cnt = 0;
    int          gap_err = 0;
    logic        prev_sel = 1'b0;
    logic [31:0] words[16];
    int          irq_delay = -1;
    int          irq_cnt = -1;
    int          rd_ptr = 0;
    logic        alu_irq = 1'b0;
    logic        irq_force = 1'b0;

    assign bus.m_irq = alu_irq | irq_force;

    always @(posedge clk) cyc <= cyc + 1;

    // ALU slave model: irq irq_delay cycles after start, cleared by 0x0002, pops words on 0x0004
    always @(posedge clk) begin
        if (irq_cnt > 0) irq_cnt <= irq_cnt - 1;
        else if (irq_cnt == 0) begin
            alu_irq <= 1'b1;
            irq_cnt <= -1;
        end
        if (reset) begin
            alu_irq <= 1'b0;
            irq_cnt <= -1;
        end else if (bus.m_sel && bus.m_wr && bus.m_addr == 16'h0000) begin
            irq_cnt <= irq_delay;
            rd_ptr  <= 0;
        end else if (bus.m_sel && bus.m_wr && bus.m_addr == 16'h0002) begin
            alu_irq <= 1'b0;
        end else if (bus.m_sel && !bus.m_wr && bus.m_addr == 16'h0004) begin
            bus.m_rdata <= words[rd_ptr];
            rd_ptr      <= rd_ptr + 1;
        end
    end

    always @(negedge clk) begin
        if (bus.m_sel) begin
            acc_log.push_back('{bus.m_wr, bus.m_addr, bus.m_wdata});
            if (prev_sel) gap_err++;
        end
        prev_sel = bus.m_sel;
        if (bus.res_valid && bus.res_ready) res_q.push_back(bus.res_data);
        if (bus.done) done_cnt++;
    end

    task automatic send(input logic [1:0] t, input logic [3:0] idx, input logic [31:0] d);
        int n = 0;
        while (!bus.cmd_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (n == 200) begin
            bad++;
            $display("FAIL send_wait: cmd_ready=%0b after %0d cycles, required 1", bus.cmd_ready, n);
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_type  = t;
        bus.cmd_idx   = idx;
        bus.cmd_data  = d;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int lim, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < lim; i++) begin
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        total += 6;
        if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready: got %0b want 1", bus.cmd_ready); end
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b want 0", bus.busy); end
        if ({bus.m_sel, bus.m_wr} !== 2'b00) begin bad++; $display("FAIL reset_sel_wr: got %b want 00", {bus.m_sel, bus.m_wr}); end
        if ({bus.m_addr, bus.m_wdata} !== 48'd0) begin bad++; $display("FAIL reset_addr_wdata: got %h want 0", {bus.m_addr, bus.m_wdata}); end
        if ({bus.res_valid, bus.res_data} !== 33'd0) begin bad++; $display("FAIL reset_res: got %h want 0", {bus.res_valid, bus.res_data}); end
        if ({bus.done, bus.ovf_err, bus.timeout} !== 3'b000) begin bad++; $display("FAIL reset_pulses: got %b want 000", {bus.done, bus.ovf_err, bus.timeout}); end
    endtask

    task automatic test_operand;
        int n0 = acc_log.size();
        send(2'd1, 4'hA, 32'd500);
        total += 4;
        if ({bus.m_sel, bus.m_wr} !== 2'b11) begin bad++; $display("FAIL opnd_sel_wr: got %b want 11", {bus.m_sel, bus.m_wr}); end
        if (bus.m_addr !== 16'h001A) begin bad++; $display("FAIL opnd_addr: got %h want 001a", bus.m_addr); end
        if (bus.m_wdata !== 32'd500) begin bad++; $display("FAIL opnd_wdata: got %0d want 500", bus.m_wdata); end
        if ({bus.busy, bus.cmd_ready} !== 2'b10) begin bad++; $display("FAIL opnd_busy_ready: got %b want 10", {bus.busy, bus.cmd_ready}); end
        @(posedge clk); #1;
        total++;
        if ({bus.m_sel, bus.cmd_ready} !== 2'b00) begin bad++; $display("FAIL opnd_gap: sel/ready got %b want 00", {bus.m_sel, bus.cmd_ready}); end
        @(posedge clk); #1;
        total += 2;
        if ({bus.m_sel, bus.cmd_ready} !== 2'b01) begin bad++; $display("FAIL opnd_ready_back: sel/ready got %b want 01", {bus.m_sel, bus.cmd_ready}); end
        if (acc_log.size() - n0 != 1) begin bad++; $display("FAIL opnd_count: got %0d accesses want 1", acc_log.size() - n0); end
    endtask

    task automatic test_reserved;
        int n0 = acc_log.size();
        int d0 = done_cnt;
        send(2'd3, 4'h0, 32'h1234);
        total++;
        if ({bus.m_sel, bus.done, bus.ovf_err, bus.cmd_ready} !== 4'b0001) begin
            bad++; $display("FAIL reserved_ignored: sel/done/ovf/ready got %b want 0001", {bus.m_sel, bus.done, bus.ovf_err, bus.cmd_ready});
        end
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (acc_log.size() != n0 || done_cnt != d0) begin bad++; $display("FAIL reserved_quiet: accesses %0d done %0d want 0 0", acc_log.size() - n0, done_cnt - d0); end
    endtask

    task automatic test_overflow;
        int n0 = acc_log.size();
        for (int i = 0; i < 8; i++) send(2'd0, 4'h0, 32'h100 + i);
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (acc_log.size() - n0 != 8) begin bad++; $display("FAIL inst_count: got %0d writes want 8", acc_log.size() - n0); end
        for (int i = 0; i < 8 && n0 + i < acc_log.size(); i++) begin
            total++;
            if (acc_log[n0+i].addr !== 16'h0003 || acc_log[n0+i].data !== 32'h100 + i) begin
                bad++; $display("FAIL inst_write[%0d]: got %h/%h want 0003/%h", i, acc_log[n0+i].addr, acc_log[n0+i].data, 32'h100 + i);
            end
        end
        send(2'd0, 4'h0, 32'hDEAD);
        total++;
        if ({bus.ovf_err, bus.m_sel, bus.cmd_ready} !== 3'b101) begin bad++; $display("FAIL ovf_pulse: ovf/sel/ready got %b want 101", {bus.ovf_err, bus.m_sel, bus.cmd_ready}); end
        @(posedge clk); #1;
        total += 2;
        if (bus.ovf_err !== 1'b0) begin bad++; $display("FAIL ovf_one_cycle: got %0b want 0", bus.ovf_err); end
        if (acc_log.size() - n0 != 8) begin bad++; $display("FAIL ovf_no_write: got %0d writes want 8", acc_log.size() - n0); end
    endtask

    task automatic test_run;
        int  n0;
        int  d0;
        bit  seen;
        for (int i = 0; i < 16; i++) words[i] = 32'hA000 + i;
        n0 = acc_log.size();
        for (int i = 0; i < 16; i++) send(2'd1, i[3:0], 32'd3 * i);
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 16 && n0 + i < acc_log.size(); i++) begin
            total++;
            if (acc_log[n0+i].addr !== 16'h0010 + i || acc_log[n0+i].data !== 32'd3 * i) begin
                bad++; $display("FAIL opnd_write[%0d]: got %h/%0d want %h/%0d", i, acc_log[n0+i].addr, acc_log[n0+i].data, 16'h0010 + i, 3 * i);
            end
        end
        res_q.delete();
        irq_delay = 50;
        bus.res_ready = 1'b1;
        n0 = acc_log.size();
        d0 = done_cnt;
        send(2'd2, 4'h0, 32'h0);
        wait_done(3000, seen);
        total++;
        if (!seen) begin bad++; $display("FAIL run_done: done not seen within 3000 cycles"); end
        @(posedge clk); #1;
        total += 4;
        if (res_q.size() != 16) begin bad++; $display("FAIL run_results: got %0d transfers want 16", res_q.size()); end
        for (int i = 0; i < 16 && i < res_q.size(); i++) begin
            total++;
            if (res_q[i] !== 32'hA000 + i) begin bad++; $display("FAIL run_data[%0d]: got %h want %h", i, res_q[i], 32'hA000 + i); end
        end
        if (acc_log.size() - n0 != 18) begin bad++; $display("FAIL run_accesses: got %0d want 18", acc_log.size() - n0); end
        else begin
            if (!acc_log[n0].wr || acc_log[n0].addr !== 16'h0000 || acc_log[n0].data !== 32'd1) begin
                bad++; $display("FAIL run_start: got %0b/%h/%h want 1/0000/1", acc_log[n0].wr, acc_log[n0].addr, acc_log[n0].data);
            end
            for (int i = 1; i <= 16; i++) begin
                total++;
                if (acc_log[n0+i].wr !== 1'b0 || acc_log[n0+i].addr !== 16'h0004) begin
                    bad++; $display("FAIL run_read[%0d]: got %0b/%h want 0/0004", i, acc_log[n0+i].wr, acc_log[n0+i].addr);
                end
            end
            if (!acc_log[n0+17].wr || acc_log[n0+17].addr !== 16'h0002 || acc_log[n0+17].data !== 32'd1) begin
                bad++; $display("FAIL run_clear: got %0b/%h/%h want 1/0002/1", acc_log[n0+17].wr, acc_log[n0+17].addr, acc_log[n0+17].data);
            end
        end
        if (done_cnt - d0 != 1 || gap_err != 0) begin bad++; $display("FAIL run_done_gap: done %0d gap errors %0d want 1 0", done_cnt - d0, gap_err); end
    endtask

    task automatic test_zero_run;
        int n0 = acc_log.size();
        send(2'd2, 4'h0, 32'h0);
        total++;
        if ({bus.done, bus.m_sel, bus.busy} !== 3'b100) begin bad++; $display("FAIL zero_run_done: done/sel/busy got %b want 100", {bus.done, bus.m_sel, bus.busy}); end
        @(posedge clk); #1;
        total += 2;
        if (bus.done !== 1'b0) begin bad++; $display("FAIL zero_run_pulse: done got %0b want 0", bus.done); end
        if (acc_log.size() != n0) begin bad++; $display("FAIL zero_run_bus: got %0d accesses want 0", acc_log.size() - n0); end
    endtask

    task automatic test_backpressure;
        int          n0;
        int          rd0;
        int          stab;
        logic [31:0] d0;
        bit          seen = 1'b0;
        for (int i = 0; i < 4; i++) words[i] = 32'hB000 + i;
        send(2'd0, 4'h0, 32'h1);
        send(2'd0, 4'h0, 32'h2);
        res_q.delete();
        bus.res_ready = 1'b0;
        irq_delay = 5;
        send(2'd2, 4'h0, 32'h0);
        for (int i = 0; i < 200 && !seen; i++) begin
            if (bus.res_valid) seen = 1'b1;
            else begin @(posedge clk); #1; end
        end
        total += 2;
        if (!seen) begin bad++; $display("FAIL bp_valid: res_valid not seen within 200 cycles"); end
        d0 = bus.res_data;
        if (d0 !== 32'hB000) begin bad++; $display("FAIL bp_first: got %h want b000", d0); end
        n0 = acc_log.size();
        rd0 = 0;
        stab = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (bus.res_data !== d0 || bus.res_valid !== 1'b1) stab++;
        end
        foreach (acc_log[i]) if (i >= n0 && acc_log[i].addr == 16'h0004) rd0++;
        total += 2;
        if (stab != 0) begin bad++; $display("FAIL bp_stable: %0d unstable cycles want 0", stab); end
        if (rd0 != 0) begin bad++; $display("FAIL bp_no_read: got %0d reads want 0", rd0); end
        bus.res_ready = 1'b1;
        wait_done(500, seen);
        @(posedge clk); #1;
        total += 2;
        if (!seen) begin bad++; $display("FAIL bp_done: done not seen within 500 cycles"); end
        if (res_q.size() != 4) begin bad++; $display("FAIL bp_count: got %0d transfers want 4", res_q.size()); end
        for (int i = 0; i < 4 && i < res_q.size(); i++) begin
            total++;
            if (res_q[i] !== 32'hB000 + i) begin bad++; $display("FAIL bp_data[%0d]: got %h want %h", i, res_q[i], 32'hB000 + i); end
        end
    endtask

    task automatic test_irq_idle;
        int n0 = acc_log.size();
        irq_force = 1'b1;
        repeat (3) @(posedge clk);
        #1 irq_force = 1'b0;
        total++;
        if (bus.busy !== 1'b0 || acc_log.size() != n0) begin bad++; $display("FAIL irq_idle: busy %0b accesses %0d want 0 0", bus.busy, acc_log.size() - n0); end
    endtask

    task automatic test_reset_midrun;
        int n0;
        int d0;
        irq_delay = -1;
        send(2'd0, 4'h0, 32'h7);
        send(2'd2, 4'h0, 32'h0);
        repeat (10) @(posedge clk);
        #1;
        total++;
        if (bus.busy !== 1'b1) begin bad++; $display("FAIL midrun_busy: got %0b want 1", bus.busy); end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n0 = acc_log.size();
        d0 = done_cnt;
        total++;
        if ({bus.busy, bus.m_sel, bus.cmd_ready} !== 3'b001) begin bad++; $display("FAIL midrun_idle: busy/sel/ready got %b want 001", {bus.busy, bus.m_sel, bus.cmd_ready}); end
        repeat (60) @(posedge clk);
        #1;
        total++;
        if (acc_log.size() != n0 || done_cnt != d0) begin bad++; $display("FAIL midrun_quiet: accesses %0d done %0d want 0 0", acc_log.size() - n0, done_cnt - d0); end
    endtask

`ifdef ALU_HOST_TIMEOUT_EN
    task automatic test_timeout;
        int c0;
        int d0;
        bit seen = 1'b0;
        irq_delay = -1;
        send(2'd0, 4'h0, 32'h9);
        send(2'd2, 4'h0, 32'h0);
        c0 = cyc;
        d0 = done_cnt;
        for (int i = 0; i < 5000 && !seen; i++) begin
            if (bus.timeout) seen = 1'b1;
            else begin @(posedge clk); #1; end
        end
        total += 3;
        if (!seen) begin bad++; $display("FAIL tmo_seen: timeout not seen within 5000 cycles"); end
        if (cyc - c0 != 4096) begin bad++; $display("FAIL tmo_latency: got %0d cycles want 4096", cyc - c0); end
        if ({bus.m_sel, bus.m_wr, bus.m_addr, bus.m_wdata} !== {2'b11, 16'h0002, 32'd1}) begin
            bad++; $display("FAIL tmo_clear: got %b/%h/%h want 11/0002/1", {bus.m_sel, bus.m_wr}, bus.m_addr, bus.m_wdata);
        end
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (bus.busy !== 1'b0 || done_cnt != d0) begin bad++; $display("FAIL tmo_idle: busy %0b done %0d want 0 0", bus.busy, done_cnt - d0); end
        send(2'd2, 4'h0, 32'h0);
        total++;
        if ({bus.done, bus.m_sel} !== 2'b10) begin bad++; $display("FAIL tmo_cnt_cleared: done/sel got %b want 10", {bus.done, bus.m_sel}); end
    endtask
`endif

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_type  = 2'd0;
        bus.cmd_idx   = 4'd0;
        bus.cmd_data  = 32'd0;
        bus.res_ready = 1'b0;
        bus.m_rdata   = 32'd0;
        test_reset();
        test_operand();
        test_reserved();
        test_overflow();
        test_run();
        test_zero_run();
        test_backpressure();
        test_irq_idle();
        test_reset_midrun();
`ifdef ALU_HOST_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
